// File: rtl/dbus_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : dbus_uart_tx
// Function : D-bus slave UART transmitter: byte TX FIFO feeding an 8N1
//            baud-timed serialiser, with STATUS/BAUDDIV/CTRL registers.
//            Define UART_TX_PARITY_EN to add an even-parity bit (CTRL[1]=PEN).
// Revision : 1.0
// ============================================================================
module dbus_uart_tx #(
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [15:0] BAUDDIV_RESET = 16'd433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ss,
    input  logic        bstart,
    input  logic        ttype,
    input  logic [1:0]  tsize,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        bdone,
    output logic        txd,
    output logic        irq
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    localparam logic [1:0] c_REG_DATA    = 2'd0;
    localparam logic [1:0] c_REG_STATUS  = 2'd1;
    localparam logic [1:0] c_REG_BAUDDIV = 2'd2;
    localparam logic [1:0] c_REG_CTRL    = 2'd3;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [31:0]     r_rdata;
    logic            r_bdone;
    logic [15:0]     r_bauddiv;
    logic            r_ie;
    logic            r_ovf;
`ifdef UART_TX_PARITY_EN
    logic            r_pen;
`endif

    // FIFO state
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    // Serialiser state
    logic [2:0]      r_state;
    logic [15:0]     r_cnt;
    logic [15:0]     r_div;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_idx;
    logic            r_txd;
`ifdef UART_TX_PARITY_EN
    logic            r_par;
    logic            r_pen_lat;
`endif

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_wr;
    logic            w_rd;
    logic [1:0]      w_reg;
    logic            w_full;
    logic            w_empty;
    logic            w_busy;
    logic            w_push;
    logic            w_pop;
    logic            w_push_ok;
    logic [7:0]      w_rd_byte;
    logic [3:0]      w_count_sat;
    logic            w_pen_rd;
    logic [31:0]     w_rdata;
    logic            w_unused_bits;

    assign w_accept  = ss & bstart;
    assign w_wr      = w_accept & ttype;
    assign w_rd      = w_accept & ~ttype;
    assign w_reg     = addr[3:2];

    assign w_full    = (r_count == c_CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_busy    = (r_state != c_ST_IDLE);
    assign w_rd_byte = r_mem[r_rd_ptr];

    assign w_push    = w_wr & (w_reg == c_REG_DATA);
    // A new frame starts from IDLE, or straight out of the last STOP cycle so
    // that queued bytes leave with no idle gap.
    assign w_pop     = ~w_empty & ((r_state == c_ST_IDLE) |
                                   ((r_state == c_ST_STOP) & (r_cnt == 16'd0)));
    // A simultaneous pop frees the slot, so a push into a full FIFO survives.
    assign w_push_ok = w_push & (~w_full | w_pop);

    // For depths below 8 the compare constant exceeds any reachable count.
    assign w_count_sat = (r_count > c_CW'(15)) ? 4'd15 : 4'(r_count);

`ifdef UART_TX_PARITY_EN
    assign w_pen_rd = r_pen;
`else
    assign w_pen_rd = 1'b0;
`endif

    // Size and byte-lane information is irrelevant: every register is
    // narrower than a byte lane split would matter for.
    assign w_unused_bits = ^{tsize, addr[1:0], wdata[31:16]};

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            c_REG_STATUS:  w_rdata = {24'd0, w_count_sat, r_ovf, w_busy, w_empty, w_full};
            c_REG_BAUDDIV: w_rdata = {16'd0, r_bauddiv};
            c_REG_CTRL:    w_rdata = {30'd0, w_pen_rd, r_ie};
            default:       w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus response and configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bdone   <= 1'b0;
            r_rdata   <= '0;
            r_bauddiv <= BAUDDIV_RESET;
            r_ie      <= 1'b0;
            r_ovf     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_pen     <= 1'b0;
`endif
        end else begin
            r_bdone <= w_accept;
            r_rdata <= w_rd ? w_rdata : '0;
            if (w_wr && (w_reg == c_REG_BAUDDIV)) begin
                r_bauddiv <= wdata[15:0];
            end
            if (w_wr && (w_reg == c_REG_CTRL)) begin
                r_ie  <= wdata[0];
`ifdef UART_TX_PARITY_EN
                r_pen <= wdata[1];
`endif
            end
            // A dropped push wins over a concurrent STATUS read so no
            // overflow event is lost.
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (w_rd && (w_reg == c_REG_STATUS)) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser: each state holds txd for r_div+1 cycles
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_div     <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par     <= 1'b0;
            r_pen_lat <= 1'b0;
`endif
        end else if (w_pop) begin
            // Divider is latched here so mid-frame BAUDDIV writes only
            // affect the next frame.
            r_state   <= c_ST_START;
            r_txd     <= 1'b0;
            r_div     <= r_bauddiv;
            r_cnt     <= r_bauddiv;
            r_shift   <= w_rd_byte;
            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            r_par     <= ^w_rd_byte;
            r_pen_lat <= r_pen;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_txd <= 1'b1;
                end
                c_ST_START: begin
                    if (r_cnt == 16'd0) begin
                        r_state   <= c_ST_DATA;
                        r_cnt     <= r_div;
                        r_bit_idx <= '0;
                        r_txd     <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                c_ST_DATA: begin
                    if (r_cnt == 16'd0) begin
                        r_cnt <= r_div;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            if (r_pen_lat) begin
                                r_state <= c_ST_PARITY;
                                r_txd   <= r_par;
                            end else
`endif
                            begin
                                r_state <= c_ST_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_ST_PARITY: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= c_ST_STOP;
                        r_cnt   <= r_div;
                        r_txd   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
`endif
                c_ST_STOP: begin
                    // Expiry with a non-empty FIFO is handled by the pop branch.
                    if (r_cnt == 16'd0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                    r_txd <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign rdata = r_rdata;
    assign bdone = r_bdone;
    assign txd   = r_txd;
    assign irq   = w_empty & r_ie;

endmodule
`default_nettype wire

// File: tb/tb_dbus_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_uart_tx
// Function : Scoreboard bench for dbus_uart_tx: bus read queue plus a
//            cycle-exact serial line monitor fed by an expected-frame queue.
// Revision : 1.0
// ============================================================================
module tb_dbus_uart_tx;

    localparam logic [3:0] c_A_DATA    = 4'h0;
    localparam logic [3:0] c_A_STATUS  = 4'h4;
    localparam logic [3:0] c_A_BAUDDIV = 4'h8;
    localparam logic [3:0] c_A_CTRL    = 4'hC;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        ss     = 1'b0;
    logic        bstart = 1'b0;
    logic        ttype  = 1'b0;
    logic [1:0]  tsize  = 2'd0;
    logic [3:0]  addr   = 4'd0;
    logic [31:0] wdata  = 32'd0;
    logic [31:0] rdata;
    logic        bdone;
    logic        txd;
    logic        irq;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] per;
        logic        pen;
        logic        contig;
    } frame_t;

    frame_t      uq[$];
    bit          mon_en   = 1'b1;
    bit          in_frame = 1'b0;

    logic [31:0] bq_exp[$];
    bit          bq_rd[$];
    string       bq_nm[$];

    dbus_uart_tx #(
        .FIFO_DEPTH    (8),
        .BAUDDIV_RESET (16'd433)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ss     (ss),
        .bstart (bstart),
        .ttype  (ttype),
        .tsize  (tsize),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .bdone  (bdone),
        .txd    (txd),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Drives one transfer for one cycle; a following issue makes it back-to-back.
    task automatic issue(input bit wr, input logic [3:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic [31:0] exp, input string nm);
        @(negedge clk);
        ss = 1'b1; bstart = 1'b1; ttype = wr; addr = a; wdata = d; tsize = sz;
        bq_exp.push_back(exp);
        bq_rd.push_back(!wr);
        bq_nm.push_back(nm);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d, input logic [1:0] sz);
        issue(1'b1, a, d, sz, 32'd0, "write");
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic [31:0] exp, input string nm);
        issue(1'b0, a, 32'd0, 2'd2, exp, nm);
    endtask

    task automatic idle();
        @(negedge clk);
        ss = 1'b0; bstart = 1'b0; ttype = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] b, input int per, input bit pen, input bit contig);
        frame_t f;
        f.data = b; f.per = 16'(per); f.pen = pen; f.contig = contig;
        uq.push_back(f);
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((uq.size() != 0 || in_frame) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        n_total++;
        if (t < 3000) n_pass++;
        else $display("FAIL %s: %0d frames still pending after 3000 cycles, expected 0", nm, uq.size());
        repeat (3) @(negedge clk);
    endtask

    // Bus scoreboard: pops one entry per bdone pulse.
    initial begin : bus_mon
        int          stall;
        logic [31:0] e;
        bit          r;
        string       nm;
        stall = 0;
        forever begin
            @(negedge clk);
            if (bdone === 1'b1) begin
                stall = 0;
                if (bq_rd.size() == 0) begin
                    n_total++;
                    $display("FAIL bus_unexpected_bdone: bdone=1 with no transfer issued, expected 0");
                end else begin
                    e  = bq_exp.pop_front();
                    r  = bq_rd.pop_front();
                    nm = bq_nm.pop_front();
                    if (r) chk(nm, rdata, e);
                end
            end else if (bq_rd.size() != 0) begin
                stall++;
                if (stall >= 3) begin
                    n_total++;
                    $display("FAIL %s: bdone=0 three cycles after transfer, expected 1", bq_nm[0]);
                    void'(bq_exp.pop_front());
                    void'(bq_rd.pop_front());
                    void'(bq_nm.pop_front());
                    stall = 0;
                end
            end
        end
    end

    // Serial monitor: checks every cycle of every bit against the queued frame.
    initial begin : uart_mon
        frame_t f;
        logic   bits [0:10];
        logic   got;
        int     nbits;
        int     gap;
        gap = 1000;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n || txd !== 1'b0) begin
                if (gap < 1000) gap++;
            end else if (uq.size() == 0) begin
                n_total++;
                $display("FAIL uart_unexpected_frame: txd=%b with no byte queued, expected 1", txd);
                for (int i = 0; i < 5000 && txd !== 1'b1; i++) @(negedge clk);
                gap = 1000;
            end else begin
                f = uq.pop_front();
                in_frame = 1'b1;
                if (f.contig) chk("uart_gap", 32'(gap), 32'd0);
                bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) bits[i+1] = f.data[i];
                if (f.pen) begin
                    bits[9] = ^f.data; bits[10] = 1'b1; nbits = 11;
                end else begin
                    bits[9] = 1'b1; bits[10] = 1'b1; nbits = 10;
                end
                for (int k = 0; k < nbits; k++) begin
                    got = bits[k];
                    for (int j = 0; j < int'(f.per); j++) begin
                        if (k != 0 || j != 0) @(negedge clk);
                        if (txd !== bits[k]) got = txd;
                    end
                    chk($sformatf("uart_byte%02h_bit%0d", f.data, k), 32'(got), 32'(bits[k]));
                end
                gap = 0;
                in_frame = 1'b0;
            end
        end
    end

    initial begin : stim
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_bdone", 32'(bdone), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        rd_reg(c_A_STATUS, 32'h02, "rst_status");
        rd_reg(c_A_BAUDDIV, 32'd433, "rst_bauddiv");
        rd_reg(c_A_CTRL, 32'd0, "rst_ctrl");
        rd_reg(c_A_DATA, 32'd0, "data_reads_zero");
        idle();

        // ss or bstart alone must not start a transfer
        @(negedge clk); ss = 1'b1; bstart = 1'b0; ttype = 1'b1; addr = c_A_DATA; wdata = 32'hFF;
        @(negedge clk); ss = 1'b0; bstart = 1'b1;
        idle();
        repeat (10) @(negedge clk);
        rd_reg(c_A_STATUS, 32'h02, "no_accept_status");
        idle();

        // BAUDDIV=3, one byte: 4 clocks per bit
        wr_reg(c_A_BAUDDIV, 32'hFFFF_0003, 2'd2);
        rd_reg(c_A_BAUDDIV, 32'd3, "bauddiv_low16");
        expect_frame(8'hA5, 4, 1'b0, 1'b0);
        wr_reg(c_A_DATA, 32'h1234_56A5, 2'd0);
        idle();
        repeat (5) @(negedge clk);
        rd_reg(4'h6, 32'h06, "status_busy");
        idle();
        wait_idle("drain_a5");
        rd_reg(c_A_STATUS, 32'h02, "status_after_a5");
        idle();

        // BAUDDIV=0: one byte in flight, then nine back-to-back writes overflow
        wr_reg(c_A_BAUDDIV, 32'd0, 2'd1);
        idle();
        expect_frame(8'h11, 1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) expect_frame(8'(8'h20 + i), 1, 1'b0, 1'b1);
        wr_reg(c_A_DATA, 32'h11, 2'd0);
        for (int i = 1; i <= 9; i++) wr_reg(c_A_DATA, 32'(8'h20 + i), 2'd0);
        rd_reg(c_A_STATUS, 32'h8D, "status_ovf_set");
        rd_reg(c_A_STATUS, 32'h85, "status_ovf_cleared");
        idle();
        wait_idle("drain_ovf");
        rd_reg(c_A_STATUS, 32'h02, "status_after_ovf");
        idle();

        // Full FIFO: push lands in the same cycle as the STOP-end pop
        expect_frame(8'h5A, 1, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) expect_frame(8'(8'h80 + i), 1, 1'b0, 1'b1);
        wr_reg(c_A_DATA, 32'h5A, 2'd0);
        for (int i = 1; i <= 8; i++) wr_reg(c_A_DATA, 32'(8'h80 + i), 2'd0);
        idle();
        idle();
        wr_reg(c_A_DATA, 32'h89, 2'd0);
        rd_reg(c_A_STATUS, 32'h85, "status_full_pushpop");
        idle();
        wait_idle("drain_full");

        // Interrupt and mid-frame BAUDDIV change
        wr_reg(c_A_CTRL, 32'h1, 2'd2);
        idle();
        chk("irq_ie_empty", 32'(irq), 32'd1);
        wr_reg(c_A_BAUDDIV, 32'd7, 2'd2);
        idle();
        expect_frame(8'h3C, 8, 1'b0, 1'b0);
        wr_reg(c_A_DATA, 32'h3C, 2'd0);
        idle();
        chk("irq_queued", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_on_pop", 32'(irq), 32'd1);
        repeat (20) @(negedge clk);
        wr_reg(c_A_BAUDDIV, 32'd1, 2'd0);
        rd_reg(c_A_BAUDDIV, 32'd1, "bauddiv_midframe");
        idle();
        expect_frame(8'hC3, 2, 1'b0, 1'b1);
        wr_reg(c_A_DATA, 32'hC3, 2'd0);
        idle();
        chk("irq_queued2", 32'(irq), 32'd0);
        wait_idle("drain_irq");
        chk("irq_drained", 32'(irq), 32'd1);

`ifdef UART_TX_PARITY_EN
        wr_reg(c_A_CTRL, 32'h3, 2'd2);
        rd_reg(c_A_CTRL, 32'h3, "ctrl_pen");
        idle();
        expect_frame(8'h07, 2, 1'b1, 1'b0);
        expect_frame(8'h03, 2, 1'b1, 1'b1);
        wr_reg(c_A_DATA, 32'h07, 2'd0);
        wr_reg(c_A_DATA, 32'h03, 2'd0);
        idle();
        wait_idle("drain_parity");
        wr_reg(c_A_CTRL, 32'h1, 2'd2);
        idle();
        expect_frame(8'h07, 2, 1'b0, 1'b0);
        wr_reg(c_A_DATA, 32'h07, 2'd0);
        idle();
        wait_idle("drain_nopar");
`else
        wr_reg(c_A_CTRL, 32'h3, 2'd2);
        rd_reg(c_A_CTRL, 32'h1, "ctrl_pen_absent");
        idle();
`endif

        // Reset in the middle of a DATA bit (byte 0x00 keeps txd low there)
        mon_en = 1'b0;
        wr_reg(c_A_DATA, 32'h00, 2'd0);
        idle();
        repeat (3) @(negedge clk);
        chk("txd_mid_data", 32'(txd), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_txd", 32'(txd), 32'd1);
        chk("rst_async_irq", 32'(irq), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        rd_reg(c_A_BAUDDIV, 32'd433, "rst2_bauddiv");
        rd_reg(c_A_STATUS, 32'h02, "rst2_status");
        rd_reg(c_A_CTRL, 32'd0, "rst2_ctrl");
        idle();
        repeat (10) @(negedge clk);

        chk("uart_queue_empty", 32'(uq.size()), 32'd0);
        chk("bus_queue_empty", 32'(bq_rd.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
